// File: rtl/axi4_to_wbc_bridge_if.sv
// ---------------------------------------------------------------------------
// axi4_to_wbc_bridge_if
//   Bundles every bus signal of the AXI4-slave / Wishbone-classic-master
//   bridge into a single interface.
//
//   Modports
//     slave  : bridge view (AXI slave side, Wishbone master side)
//     master : environment view (AXI master driving requests, WB slave
//              answering cycles)
//
//   Signal groups (names keep the bridge's port names)
//     AW  : i_axi_aw{valid,id,addr,len,burst}, o_axi_awready
//     W   : i_axi_w{valid,data,strb,last},     o_axi_wready
//     B   : o_axi_b{valid,id,resp},            i_axi_bready
//     AR  : i_axi_ar{valid,id,addr,len,burst}, o_axi_arready
//     R   : o_axi_r{valid,id,data,resp,last},  i_axi_rready
//     WB  : o_wb_{cyc,stb,we,addr,data,sel},   i_wb_{ack,err,data}
// ---------------------------------------------------------------------------
interface axi4_to_wbc_bridge_if #(
   parameter int AW = 30,
   parameter int IW = 4
);
   // write address channel
   logic              i_axi_awvalid;
   logic [IW-1:0]     i_axi_awid;
   logic [AW+1:0]     i_axi_awaddr;
   logic [7:0]        i_axi_awlen;
   logic [1:0]        i_axi_awburst;
   logic              o_axi_awready;
   // write data channel
   logic              i_axi_wvalid;
   logic [31:0]       i_axi_wdata;
   logic [3:0]        i_axi_wstrb;
   logic              i_axi_wlast;
   logic              o_axi_wready;
   // write response channel
   logic              o_axi_bvalid;
   logic [IW-1:0]     o_axi_bid;
   logic [1:0]        o_axi_bresp;
   logic              i_axi_bready;
   // read address channel
   logic              i_axi_arvalid;
   logic [IW-1:0]     i_axi_arid;
   logic [AW+1:0]     i_axi_araddr;
   logic [7:0]        i_axi_arlen;
   logic [1:0]        i_axi_arburst;
   logic              o_axi_arready;
   // read data channel
   logic              o_axi_rvalid;
   logic [IW-1:0]     o_axi_rid;
   logic [31:0]       o_axi_rdata;
   logic [1:0]        o_axi_rresp;
   logic              o_axi_rlast;
   logic              i_axi_rready;
   // Wishbone classic master
   logic              o_wb_cyc;
   logic              o_wb_stb;
   logic              o_wb_we;
   logic [AW-1:0]     o_wb_addr;
   logic [31:0]       o_wb_data;
   logic [3:0]        o_wb_sel;
   logic              i_wb_ack;
   logic              i_wb_err;
   logic [31:0]       i_wb_data;

   modport slave (
      input  i_axi_awvalid, i_axi_awid, i_axi_awaddr, i_axi_awlen, i_axi_awburst,
      output o_axi_awready,
      input  i_axi_wvalid, i_axi_wdata, i_axi_wstrb, i_axi_wlast,
      output o_axi_wready,
      output o_axi_bvalid, o_axi_bid, o_axi_bresp,
      input  i_axi_bready,
      input  i_axi_arvalid, i_axi_arid, i_axi_araddr, i_axi_arlen, i_axi_arburst,
      output o_axi_arready,
      output o_axi_rvalid, o_axi_rid, o_axi_rdata, o_axi_rresp, o_axi_rlast,
      input  i_axi_rready,
      output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel,
      input  i_wb_ack, i_wb_err, i_wb_data
   );

   modport master (
      output i_axi_awvalid, i_axi_awid, i_axi_awaddr, i_axi_awlen, i_axi_awburst,
      input  o_axi_awready,
      output i_axi_wvalid, i_axi_wdata, i_axi_wstrb, i_axi_wlast,
      input  o_axi_wready,
      input  o_axi_bvalid, o_axi_bid, o_axi_bresp,
      output i_axi_bready,
      output i_axi_arvalid, i_axi_arid, i_axi_araddr, i_axi_arlen, i_axi_arburst,
      input  o_axi_arready,
      input  o_axi_rvalid, o_axi_rid, o_axi_rdata, o_axi_rresp, o_axi_rlast,
      output i_axi_rready,
      input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel,
      output i_wb_ack, i_wb_err, i_wb_data
   );
endinterface

// File: rtl/axi4_to_wbc_bridge.sv
// ---------------------------------------------------------------------------
// axi4_to_wbc_bridge
//   AXI4 (burst-capable) slave to Wishbone classic master, 32-bit data.
//   One AXI transaction in flight; every AXI beat becomes one classic WB
//   cycle, with at least one idle cycle between consecutive WB cycles.
//
//   Ports
//     i_clk    : clock
//     i_reset  : synchronous active-high reset (abandons any transaction,
//                no response is issued for it)
//     bus      : axi4_to_wbc_bridge_if.slave -- AXI AW/W/B/AR/R channels and
//                the Wishbone classic master signals
//
//   Parameters
//     AW : Wishbone word-address width (AXI byte address is AW+2 bits, AW>=10)
//     IW : AXI ID width
//
//   Notes
//     - AW/AR ready are combinational in IDLE and reflect the arbiter grant;
//       every other output comes straight from a register.
//     - Ties between AW and AR go to the side not granted last; the first
//       tie after reset goes to the read.
//     - INCR bursts increment only address bits [11:2] (wrap inside 4 KB,
//       upper bits held). FIXED keeps the address. WRAP and the reserved
//       encoding do no WB access and answer SLVERR for every beat.
//     - ack and err in the same cycle is treated as err.
// ---------------------------------------------------------------------------
module axi4_to_wbc_bridge #(
   parameter int AW = 30,
   parameter int IW = 4
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   axi4_to_wbc_bridge_if.slave   bus
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_WR_DATA = 3'd1;
   localparam logic [2:0] S_WR_BUS  = 3'd2;
   localparam logic [2:0] S_WR_RESP = 3'd3;
   localparam logic [2:0] S_RD_BUS  = 3'd4;
   localparam logic [2:0] S_RD_DATA = 3'd5;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // FSM and transaction context
   logic [2:0]      state_r;
   logic [IW-1:0]   id_r;
   logic [AW-1:0]   addr_r;
   logic [7:0]      cnt_r;        // beats remaining after the current one
   logic [1:0]      burst_r;
   logic            bad_burst_r;  // WRAP/reserved: no WB traffic, SLVERR
   logic            err_r;        // sticky write error over the burst
   logic            prio_rd_r;    // 1: read wins the next AW/AR tie

   // registered outputs
   logic            wb_cyc_r;
   logic            wb_we_r;
   logic [31:0]     wb_data_r;
   logic [3:0]      wb_sel_r;
   logic            wready_r;
   logic            bvalid_r;
   logic [1:0]      bresp_r;
   logic            rvalid_r;
   logic [31:0]     rdata_r;
   logic [1:0]      rresp_r;
   logic            rlast_r;

   // arbiter and WB terminate decode
   logic            grant_rd_s;
   logic            grant_wr_s;
   logic            wb_term_s;
   logic            wb_err_s;
   logic            unused_s;

   // Next word address for the beat that follows: INCR wraps inside 4 KB.
   function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a,
                                                input logic [1:0]    burst);
      logic [AW-1:0] n;
      n = a;
      if (burst == BURST_INCR) begin
         n[9:0] = a[9:0] + 10'd1;
      end else begin
         n = a;
      end
      return n;
   endfunction

   // Only FIXED and INCR bursts are forwarded to the WB side.
   function automatic logic burst_supported(input logic [1:0] burst);
      return (burst == BURST_FIXED) || (burst == BURST_INCR);
   endfunction

   assign wb_err_s  = bus.i_wb_err;
   assign wb_term_s = bus.i_wb_ack | bus.i_wb_err;

   // wlast is deliberately ignored (beats are counted from len) and the AXI
   // byte-offset bits have no meaning on a word-addressed WB bus.
   assign unused_s = ^{bus.i_axi_wlast, bus.i_axi_awaddr[1:0], bus.i_axi_araddr[1:0]};

   // Arbiter: grants AW or AR only while idle; ties go to prio_rd_r's side.
   always_comb begin
      grant_rd_s = 1'b0;
      grant_wr_s = 1'b0;
      if (!i_reset && (state_r == S_IDLE)) begin
         if (bus.i_axi_arvalid && (!bus.i_axi_awvalid || prio_rd_r)) begin
            grant_rd_s = 1'b1;
         end else if (bus.i_axi_awvalid) begin
            grant_wr_s = 1'b1;
         end else begin
            grant_rd_s = 1'b0;
            grant_wr_s = 1'b0;
         end
      end else begin
         grant_rd_s = 1'b0;
         grant_wr_s = 1'b0;
      end
   end

   assign bus.o_axi_awready = grant_wr_s;
   assign bus.o_axi_arready = grant_rd_s;
   assign bus.o_axi_wready  = wready_r;
   assign bus.o_axi_bvalid  = bvalid_r;
   assign bus.o_axi_bid     = id_r;
   assign bus.o_axi_bresp   = bresp_r;
   assign bus.o_axi_rvalid  = rvalid_r;
   assign bus.o_axi_rid     = id_r;
   assign bus.o_axi_rdata   = rdata_r;
   assign bus.o_axi_rresp   = rresp_r;
   assign bus.o_axi_rlast   = rlast_r;
   assign bus.o_wb_cyc      = wb_cyc_r;
   assign bus.o_wb_stb      = wb_cyc_r;   // classic: one strobe per cycle
   assign bus.o_wb_we       = wb_we_r;
   assign bus.o_wb_addr     = addr_r;
   assign bus.o_wb_data     = wb_data_r;
   assign bus.o_wb_sel      = wb_sel_r;

   // Transaction FSM with all context and output registers.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_r     <= S_IDLE;
         id_r        <= '0;
         addr_r      <= '0;
         cnt_r       <= 8'd0;
         burst_r     <= 2'b00;
         bad_burst_r <= 1'b0;
         err_r       <= 1'b0;
         prio_rd_r   <= 1'b1;
         wb_cyc_r    <= 1'b0;
         wb_we_r     <= 1'b0;
         wb_data_r   <= 32'd0;
         wb_sel_r    <= 4'h0;
         wready_r    <= 1'b0;
         bvalid_r    <= 1'b0;
         bresp_r     <= RESP_OKAY;
         rvalid_r    <= 1'b0;
         rdata_r     <= 32'd0;
         rresp_r     <= RESP_OKAY;
         rlast_r     <= 1'b0;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (grant_rd_s) begin
                  id_r        <= bus.i_axi_arid;
                  addr_r      <= bus.i_axi_araddr[AW+1:2];
                  cnt_r       <= bus.i_axi_arlen;
                  burst_r     <= bus.i_axi_arburst;
                  bad_burst_r <= !burst_supported(bus.i_axi_arburst);
                  prio_rd_r   <= 1'b0;
                  if (burst_supported(bus.i_axi_arburst)) begin
                     wb_cyc_r <= 1'b1;
                     wb_we_r  <= 1'b0;
                     wb_sel_r <= 4'hF;
                     state_r  <= S_RD_BUS;
                  end else begin
                     // unsupported burst: answer straight from the bridge
                     rvalid_r <= 1'b1;
                     rdata_r  <= 32'd0;
                     rresp_r  <= RESP_SLVERR;
                     rlast_r  <= (bus.i_axi_arlen == 8'd0);
                     state_r  <= S_RD_DATA;
                  end
               end else if (grant_wr_s) begin
                  id_r        <= bus.i_axi_awid;
                  addr_r      <= bus.i_axi_awaddr[AW+1:2];
                  cnt_r       <= bus.i_axi_awlen;
                  burst_r     <= bus.i_axi_awburst;
                  bad_burst_r <= !burst_supported(bus.i_axi_awburst);
                  err_r       <= 1'b0;
                  prio_rd_r   <= 1'b1;
                  wready_r    <= 1'b1;
                  state_r     <= S_WR_DATA;
               end else begin
                  state_r <= S_IDLE;
               end
            end

            S_WR_DATA: begin
               if (bus.i_axi_wvalid && wready_r) begin
                  if (bad_burst_r) begin
                     // drain the beats without touching the WB bus
                     if (cnt_r == 8'd0) begin
                        wready_r <= 1'b0;
                        bvalid_r <= 1'b1;
                        bresp_r  <= RESP_SLVERR;
                        state_r  <= S_WR_RESP;
                     end else begin
                        cnt_r <= cnt_r - 8'd1;
                     end
                  end else begin
                     wb_data_r <= bus.i_axi_wdata;
                     wb_sel_r  <= bus.i_axi_wstrb;
                     wready_r  <= 1'b0;
                     wb_cyc_r  <= 1'b1;
                     wb_we_r   <= 1'b1;
                     state_r   <= S_WR_BUS;
                  end
               end else begin
                  state_r <= S_WR_DATA;
               end
            end

            S_WR_BUS: begin
               if (wb_term_s) begin
                  wb_cyc_r <= 1'b0;
                  wb_we_r  <= 1'b0;
                  if (wb_err_s) begin
                     err_r <= 1'b1;
                  end else begin
                     err_r <= err_r;
                  end
                  if (cnt_r == 8'd0) begin
                     bvalid_r <= 1'b1;
                     bresp_r  <= (err_r || wb_err_s) ? RESP_SLVERR : RESP_OKAY;
                     state_r  <= S_WR_RESP;
                  end else begin
                     cnt_r    <= cnt_r - 8'd1;
                     addr_r   <= next_addr(addr_r, burst_r);
                     wready_r <= 1'b1;
                     state_r  <= S_WR_DATA;
                  end
               end else begin
                  state_r <= S_WR_BUS;
               end
            end

            S_WR_RESP: begin
               if (bus.i_axi_bready) begin
                  bvalid_r <= 1'b0;
                  state_r  <= S_IDLE;
               end else begin
                  state_r <= S_WR_RESP;
               end
            end

            S_RD_BUS: begin
               if (wb_term_s) begin
                  wb_cyc_r <= 1'b0;
                  rvalid_r <= 1'b1;
                  rdata_r  <= wb_err_s ? 32'd0 : bus.i_wb_data;
                  rresp_r  <= wb_err_s ? RESP_SLVERR : RESP_OKAY;
                  rlast_r  <= (cnt_r == 8'd0);
                  addr_r   <= next_addr(addr_r, burst_r);
                  state_r  <= S_RD_DATA;
               end else begin
                  state_r <= S_RD_BUS;
               end
            end

            S_RD_DATA: begin
               if (bus.i_axi_rready) begin
                  if (cnt_r == 8'd0) begin
                     rvalid_r <= 1'b0;
                     rlast_r  <= 1'b0;
                     state_r  <= S_IDLE;
                  end else if (bad_burst_r) begin
                     // next error beat follows immediately
                     cnt_r   <= cnt_r - 8'd1;
                     rlast_r <= (cnt_r == 8'd1);
                     state_r <= S_RD_DATA;
                  end else begin
                     cnt_r    <= cnt_r - 8'd1;
                     rvalid_r <= 1'b0;
                     rlast_r  <= 1'b0;
                     wb_cyc_r <= 1'b1;
                     wb_we_r  <= 1'b0;
                     wb_sel_r <= 4'hF;
                     state_r  <= S_RD_BUS;
                  end
               end else begin
                  state_r <= S_RD_DATA;
               end
            end

            default: begin
               state_r  <= S_IDLE;
               wb_cyc_r <= 1'b0;
               wb_we_r  <= 1'b0;
               wready_r <= 1'b0;
               bvalid_r <= 1'b0;
               rvalid_r <= 1'b0;
            end
         endcase
      end
   end

endmodule
